// File: rtl/game_pkg.sv
// Shared game-flow types and sizing constants, also imported by the collision logic.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BANNER1,
        ST_PLAY1,
        ST_BANNER2,
        ST_PLAY2,
        ST_WIN,
        ST_LOSE
    } game_state_t;

    localparam int unsigned DEF_NUM_BLOCKS = 10;
    localparam int unsigned DEF_NUM_RECTS  = 3;
    localparam int unsigned SCORE_W        = 8;

endpackage

// File: rtl/frame_timer.sv
// Counts frame_start pulses while enabled; sync clear; flags the last frame of a LIMIT-long span.
module frame_timer #(
    parameter int unsigned LIMIT = 120
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic tick,
    output logic tc_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && tick && !tc_c) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign tc_c = (count_q == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/level_sequencer.sv
// Level state machine, per-target alive masks, score and lives; all changes aligned to frame_start.
module level_sequencer
    import game_pkg::*;
#(
    parameter int unsigned           NUM_BLOCKS    = DEF_NUM_BLOCKS,
    parameter int unsigned           NUM_RECTS     = DEF_NUM_RECTS,
    parameter int unsigned           BANNER_FRAMES = 120,
    parameter logic [NUM_BLOCKS-1:0] L2_BLOCK_MASK = 10'b11111_00000,
    parameter logic [1:0]            START_LIVES   = 2'd3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_start,
    input  logic                  start_btn,
    input  logic [NUM_BLOCKS-1:0] block_hit,
    input  logic [NUM_RECTS-1:0]  rect_hit,
    input  logic                  ball_lost,
    output logic [NUM_BLOCKS-1:0] block_ready,
    output logic [NUM_RECTS-1:0]  rect_ready,
    output logic                  level_one,
    output logic                  level_two,
    output logic                  play_en,
    output logic                  game_won,
    output logic                  game_over,
    output logic [SCORE_W-1:0]    score,
    output logic [1:0]            lives
);

    localparam int unsigned HIT_W = $clog2(NUM_BLOCKS + NUM_RECTS + 1);
    localparam int unsigned SUM_W = SCORE_W + 1;

    game_state_t           state_q, state_d;
    logic [NUM_BLOCKS-1:0] blk_q, blk_d;
    logic [NUM_RECTS-1:0]  rect_q, rect_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [1:0]            lives_q, lives_d;
    logic                  pend_q, pend_d;
    logic                  level_one_q, level_one_d;
    logic                  level_two_q, level_two_d;
    logic                  play_en_q, play_en_d;
    logic                  game_won_q, game_won_d;
    logic                  game_over_q, game_over_d;

    logic                  tmr_clr_c, tmr_en_c, tmr_tc_c;
    logic [NUM_BLOCKS-1:0] new_blk_c;
    logic [NUM_RECTS-1:0]  new_rect_c;
    logic [HIT_W-1:0]      hit_cnt_c;
    logic [SUM_W-1:0]      sum_c;
    logic                  last_life_c;

    assign tmr_en_c = (state_q == ST_BANNER1) || (state_q == ST_BANNER2);

    frame_timer #(.LIMIT(BANNER_FRAMES)) u_banner_timer (
        .clk   (Clk),
        .reset (Reset),
        .clear (tmr_clr_c),
        .en    (tmr_en_c),
        .tick  (frame_start),
        .tc_c  (tmr_tc_c)
    );

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        rect_d      = rect_q;
        score_d     = score_q;
        lives_d     = lives_q;
        pend_d      = pend_q;
        tmr_clr_c   = 1'b0;
        new_blk_c   = '0;
        new_rect_c  = '0;
        hit_cnt_c   = '0;
        sum_c       = '0;
        last_life_c = ball_lost && (lives_q == 2'd1);

        unique case (state_q)
            ST_IDLE: begin
                blk_d  = '0;
                rect_d = '0;
                if (frame_start && start_btn) begin
                    state_d   = ST_BANNER1;
                    blk_d     = '1;
                    lives_d   = START_LIVES;
                    score_d   = '0;
                    tmr_clr_c = 1'b1;
                end
            end
            ST_BANNER1: if (frame_start && tmr_tc_c) state_d = ST_PLAY1;
            ST_BANNER2: if (frame_start && tmr_tc_c) state_d = ST_PLAY2;
            ST_PLAY1, ST_PLAY2: begin
                // Only hits on live targets score; the clear check below uses the pre-hit masks.
                new_blk_c  = block_hit & blk_q;
                new_rect_c = rect_hit & rect_q;
                blk_d      = blk_q & ~block_hit;
                rect_d     = rect_q & ~rect_hit;
                for (int i = 0; i < NUM_BLOCKS; i++) hit_cnt_c = hit_cnt_c + HIT_W'(new_blk_c[i]);
                for (int i = 0; i < NUM_RECTS; i++)  hit_cnt_c = hit_cnt_c + HIT_W'(new_rect_c[i]);
                sum_c   = SUM_W'(score_q) + SUM_W'(hit_cnt_c);
                score_d = sum_c[SCORE_W] ? '1 : sum_c[SCORE_W-1:0];

                if (ball_lost && (lives_q != 2'd0)) begin
                    lives_d = lives_q - 2'd1;
                    if (last_life_c) pend_d = 1'b1;
                end

                if (frame_start) begin
                    if (pend_q) begin
                        state_d = ST_LOSE;
                        pend_d  = 1'b0;
                    end else if (!last_life_c && (blk_q == '0) && (rect_q == '0)) begin
                        if (state_q == ST_PLAY1) begin
                            state_d   = ST_BANNER2;
                            blk_d     = L2_BLOCK_MASK;
                            rect_d    = '1;
                            tmr_clr_c = 1'b1;
                        end else begin
                            state_d = ST_WIN;
                        end
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (frame_start && start_btn) begin
                    state_d = ST_IDLE;
                    blk_d   = '0;
                    rect_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        level_one_d = (state_d == ST_BANNER1);
        level_two_d = (state_d == ST_BANNER2);
        play_en_d   = ((state_d == ST_PLAY1) || (state_d == ST_PLAY2)) && !pend_d;
        game_won_d  = (state_d == ST_WIN);
        game_over_d = (state_d == ST_LOSE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            blk_q       <= '0;
            rect_q      <= '0;
            score_q     <= '0;
            lives_q     <= '0;
            pend_q      <= 1'b0;
            level_one_q <= 1'b0;
            level_two_q <= 1'b0;
            play_en_q   <= 1'b0;
            game_won_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            rect_q      <= rect_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            pend_q      <= pend_d;
            level_one_q <= level_one_d;
            level_two_q <= level_two_d;
            play_en_q   <= play_en_d;
            game_won_q  <= game_won_d;
            game_over_q <= game_over_d;
        end
    end

    assign block_ready = blk_q;
    assign rect_ready  = rect_q;
    assign level_one   = level_one_q;
    assign level_two   = level_two_q;
    assign play_en     = play_en_q;
    assign game_won    = game_won_q;
    assign game_over   = game_over_q;
    assign score       = score_q;
    assign lives       = lives_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed test-plan scenarios plus randomized traffic, checked every cycle against a game-rule model.
module tb_level_sequencer;

    localparam int BF = 120;
    localparam int M_IDLE = 0, M_B1 = 1, M_P1 = 2, M_B2 = 3, M_P2 = 4, M_WIN = 5, M_LOSE = 6;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_start, start_btn, ball_lost;
    logic [9:0] block_hit;
    logic [2:0] rect_hit;
    logic [9:0] block_ready;
    logic [2:0] rect_ready;
    logic       level_one, level_two, play_en, game_won, game_over;
    logic [7:0] score;
    logic [1:0] lives;

    int checks = 0;
    int errors = 0;

    // reference model of the game rules
    int         m_st;
    logic [9:0] m_blk;
    logic [2:0] m_rect;
    int         m_score, m_lives, m_cnt;
    bit         m_pend;

    level_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .start_btn   (start_btn),
        .block_hit   (block_hit),
        .rect_hit    (rect_hit),
        .ball_lost   (ball_lost),
        .block_ready (block_ready),
        .rect_ready  (rect_ready),
        .level_one   (level_one),
        .level_two   (level_two),
        .play_en     (play_en),
        .game_won    (game_won),
        .game_over   (game_over),
        .score       (score),
        .lives       (lives)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int old_lives;
        logic [9:0] old_blk;
        logic [2:0] old_rect;
        bit old_pend;
        if (Reset) begin
            m_st = M_IDLE; m_blk = '0; m_rect = '0; m_score = 0; m_lives = 0; m_cnt = 0; m_pend = 0;
            return;
        end
        case (m_st)
            M_IDLE: begin
                m_blk = '0; m_rect = '0;
                if (frame_start && start_btn) begin
                    m_st = M_B1; m_blk = 10'h3FF; m_lives = 3; m_score = 0; m_cnt = 0;
                end
            end
            M_B1, M_B2: begin
                if (frame_start) begin
                    if (m_cnt == BF - 1) m_st = (m_st == M_B1) ? M_P1 : M_P2;
                    else m_cnt++;
                end
            end
            M_P1, M_P2: begin
                old_lives = m_lives; old_blk = m_blk; old_rect = m_rect; old_pend = m_pend;
                m_score += $countones(block_hit & m_blk) + $countones(rect_hit & m_rect);
                if (m_score > 255) m_score = 255;
                m_blk  = m_blk & ~block_hit;
                m_rect = m_rect & ~rect_hit;
                if (ball_lost && old_lives > 0) begin
                    m_lives = old_lives - 1;
                    if (old_lives == 1) m_pend = 1;
                end
                if (frame_start) begin
                    if (old_pend) begin
                        m_st = M_LOSE; m_pend = 0;
                    end else if (!(ball_lost && old_lives == 1) && old_blk == 0 && old_rect == 0) begin
                        if (m_st == M_P1) begin
                            m_st = M_B2; m_blk = 10'h3E0; m_rect = 3'b111; m_cnt = 0;
                        end else begin
                            m_st = M_WIN;
                        end
                    end
                end
            end
            default: begin
                if (frame_start && start_btn) begin
                    m_st = M_IDLE; m_blk = '0; m_rect = '0;
                end
            end
        endcase
    endtask

    task automatic chk_all();
        chk("block_ready", 32'(block_ready), 32'(m_blk));
        chk("rect_ready",  32'(rect_ready),  32'(m_rect));
        chk("level_one",   32'(level_one),   32'(m_st == M_B1));
        chk("level_two",   32'(level_two),   32'(m_st == M_B2));
        chk("play_en",     32'(play_en),     32'((m_st == M_P1 || m_st == M_P2) && !m_pend));
        chk("game_won",    32'(game_won),    32'(m_st == M_WIN));
        chk("game_over",   32'(game_over),   32'(m_st == M_LOSE));
        chk("score",       32'(score),       32'(m_score));
        chk("lives",       32'(lives),       32'(m_lives));
    endtask

    // Called at a negedge: drive, advance model, cross a posedge, compare at the next negedge.
    task automatic cycle(input logic rst, input logic fs, input logic sb,
                         input logic [9:0] bh, input logic [2:0] rh, input logic bl);
        Reset = rst; frame_start = fs; start_btn = sb; block_hit = bh; rect_hit = rh; ball_lost = bl;
        model_step();
        @(negedge Clk);
        chk_all();
        Reset = 0; frame_start = 0; start_btn = 0; block_hit = '0; rect_hit = '0; ball_lost = 0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, '0, '0, 0);
    endtask

    initial begin
        Reset = 1; frame_start = 0; start_btn = 0; block_hit = '0; rect_hit = '0; ball_lost = 0;
        m_st = M_IDLE; m_blk = '0; m_rect = '0; m_score = 0; m_lives = 0; m_cnt = 0; m_pend = 0;
        @(negedge Clk);
        cycle(1, 0, 0, '0, '0, 0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_flags", 32'({level_one, level_two, play_en, game_won, game_over}), 32'd0);

        // start and level-1 banner
        cycle(0, 1, 1, '0, '0, 0);
        chk("start_l1", 32'(level_one), 32'd1);
        chk("start_blk", 32'(block_ready), 32'h3FF);
        frames(BF - 1);
        chk("banner_hold", 32'(level_one), 32'd1);
        frames(1);
        chk("play1_en", 32'(play_en), 32'd1);
        chk("play1_l1", 32'(level_one), 32'd0);

        // duplicate hit ignored
        cycle(0, 0, 0, 10'b0000000101, '0, 0);
        chk("hit1_score", 32'(score), 32'd2);
        cycle(0, 0, 0, 10'b0000000101, '0, 0);
        chk("hit2_score", 32'(score), 32'd2);
        chk("hit2_blk", 32'(block_ready), 32'h3FA);

        // saturation from 254 with three simultaneous hits
        force dut.score_q = 8'd254;
        release dut.score_q;
        m_score = 254;
        cycle(0, 0, 0, 10'b0000111000, '0, 0);
        chk("sat_score", 32'(score), 32'd255);

        // last hit coincides with frame_start: clear happens one frame later
        cycle(0, 0, 0, 10'h1C2, '0, 0);
        cycle(0, 1, 0, 10'h200, '0, 0);
        chk("late_clear_l2", 32'(level_two), 32'd0);
        chk("late_clear_play", 32'(play_en), 32'd1);
        frames(1);
        chk("b2_l2", 32'(level_two), 32'd1);
        chk("b2_blk", 32'(block_ready), 32'h3E0);
        chk("b2_rect", 32'(rect_ready), 32'h7);
        frames(BF);
        chk("play2_en", 32'(play_en), 32'd1);

        // three lost balls -> LOSE at the next frame
        cycle(0, 0, 0, '0, '0, 1);
        chk("lives2", 32'(lives), 32'd2);
        cycle(0, 0, 0, '0, '0, 1);
        chk("lives1", 32'(lives), 32'd1);
        cycle(0, 0, 0, '0, '0, 1);
        chk("lives0_play", 32'(play_en), 32'd0);
        cycle(0, 0, 0, '0, '0, 1);
        chk("no_underflow", 32'(lives), 32'd0);
        chk("not_over_yet", 32'(game_over), 32'd0);
        frames(1);
        chk("game_over", 32'(game_over), 32'd1);
        chk("lose_hold_blk", 32'(block_ready), 32'h3E0);
        cycle(0, 1, 1, '0, '0, 0);
        chk("back_idle_blk", 32'(block_ready), 32'h0);

        // reset mid-play
        cycle(0, 1, 1, '0, '0, 0);
        frames(BF);
        cycle(0, 0, 0, 10'h00F, '0, 0);
        chk("pre_rst_score", 32'(score), 32'd4);
        cycle(1, 0, 0, 10'h010, '0, 0);
        chk("midrst_score", 32'(score), 32'd0);
        chk("midrst_blk", 32'(block_ready), 32'd0);
        chk("midrst_flags", 32'({level_one, level_two, play_en, game_won, game_over}), 32'd0);

        // randomized traffic
        for (int n = 0; n < 20000; n++) begin
            logic       r_rst, r_fs, r_sb, r_bl;
            logic [9:0] r_bh;
            logic [2:0] r_rh;
            r_rst = ($urandom_range(0, 4999) == 0);
            r_fs  = ($urandom_range(0, 1) == 0);
            r_sb  = ($urandom_range(0, 5) == 0);
            r_bl  = ($urandom_range(0, 299) == 0);
            r_bh  = '0;
            r_rh  = '0;
            if ($urandom_range(0, 3) == 0) r_bh = 10'(1) << $urandom_range(0, 9);
            if ($urandom_range(0, 19) == 0) r_bh = 10'($urandom);
            if ($urandom_range(0, 5) == 0) r_rh = 3'($urandom);
            cycle(r_rst, r_fs, r_sb, r_bh, r_rh, r_bl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
